// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Groups the decode-side request handshake and the word-addressed data bus
//   of the load/store unit.
//   Decode side : mem_req, mem_we, mem_byte_enable, mem_unsigned, mem_addr,
//                 mem_wdata -> LSU; mem_valid, mem_rdata, mem_error <- LSU.
//   Memory side : bus_req, bus_we, bus_addr, bus_be, bus_wdata <- LSU;
//                 bus_rdata, bus_ack -> LSU.
//   master : environment view (decode unit + data memory).
//   slave  : load/store unit view.
interface load_store_unit_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4
);
    logic                       mem_req;
    logic                       mem_we;
    logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable;
    logic                       mem_unsigned;
    logic [DATA_WIDTH-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic                       mem_valid;
    logic [DATA_WIDTH-1:0]      mem_rdata;
    logic                       mem_error;

    logic                       bus_req;
    logic                       bus_we;
    logic [DATA_WIDTH-1:0]      bus_addr;
    logic [BYTE_DATA_WIDTH-1:0] bus_be;
    logic [DATA_WIDTH-1:0]      bus_wdata;
    logic [DATA_WIDTH-1:0]      bus_rdata;
    logic                       bus_ack;

    modport master (
        output mem_req, mem_we, mem_byte_enable, mem_unsigned, mem_addr, mem_wdata,
        output bus_rdata, bus_ack,
        input  mem_valid, mem_rdata, mem_error,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport slave (
        input  mem_req, mem_we, mem_byte_enable, mem_unsigned, mem_addr, mem_wdata,
        input  bus_rdata, bus_ack,
        output mem_valid, mem_rdata, mem_error,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory responder for the decode unit's four-phase mem_req/mem_valid
//   handshake. Accepts one request, checks size/alignment, runs a single
//   word-addressed bus transaction, and returns the shifted and extended load
//   result or an error (misaligned, invalid enable, bus timeout).
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-high reset
//     lsu  - load_store_unit_if.slave (request handshake + data bus)
//   Parameters:
//     DATA_WIDTH (32 only), BYTE_DATA_WIDTH (= DATA_WIDTH/8),
//     TIMEOUT_CYCLES (bus_ack wait limit, 0 = no timeout)
module load_store_unit #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave lsu
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic                       valid_q, valid_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       error_q, error_d;
    logic                       breq_q, breq_d;
    logic                       bwe_q, bwe_d;
    logic [DATA_WIDTH-1:0]      baddr_q, baddr_d;
    logic [BYTE_DATA_WIDTH-1:0] bbe_q, bbe_d;
    logic [DATA_WIDTH-1:0]      bwdata_q, bwdata_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       we_q, we_d;
    logic [BYTE_DATA_WIDTH-1:0] be_q, be_d;
    logic                       uns_q, uns_d;
    logic [1:0]                 off_q, off_d;

    logic                       req_bad;
    logic [DATA_WIDTH-1:0]      shifted;
    logic [DATA_WIDTH-1:0]      load_val;

    // Request legality, evaluated on the live inputs while IDLE.
    always_comb begin
        req_bad = 1'b0;
        unique case (lsu.mem_byte_enable)
            4'b0001: req_bad = 1'b0;
            4'b0011: req_bad = lsu.mem_addr[0];
            4'b1111: req_bad = (lsu.mem_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Bring the addressed lanes down to bit 0, then extend by access size.
    always_comb begin
        shifted  = lsu.bus_rdata >> {off_q, 3'b000};
        load_val = shifted;
        case (be_q)
            4'b0001: load_val = {{(DATA_WIDTH-8){~uns_q & shifted[7]}}, shifted[7:0]};
            4'b0011: load_val = {{(DATA_WIDTH-16){~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        breq_d   = breq_q;
        bwe_d    = bwe_q;
        baddr_d  = baddr_q;
        bbe_d    = bbe_q;
        bwdata_d = bwdata_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        be_d     = be_q;
        uns_d    = uns_q;
        off_d    = off_q;

        unique case (state_q)
            IDLE: begin
                if (lsu.mem_req) begin
                    we_d  = lsu.mem_we;
                    be_d  = lsu.mem_byte_enable;
                    uns_d = lsu.mem_unsigned;
                    off_d = lsu.mem_addr[1:0];
                    if (req_bad) begin
                        valid_d = 1'b1;
                        error_d = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end else begin
                        breq_d   = 1'b1;
                        bwe_d    = lsu.mem_we;
                        baddr_d  = {lsu.mem_addr[DATA_WIDTH-1:2], 2'b00};
                        bbe_d    = lsu.mem_byte_enable << lsu.mem_addr[1:0];
                        bwdata_d = lsu.mem_wdata << {lsu.mem_addr[1:0], 3'b000};
                        cnt_d    = '0;
                        state_d  = BUS;
                    end
                end
            end
            BUS: begin
                if (lsu.bus_ack) begin
                    breq_d  = 1'b0;
                    valid_d = 1'b1;
                    error_d = 1'b0;
                    rdata_d = we_q ? '0 : load_val;
                    state_d = DONE;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    // cnt runs 0..TIMEOUT_CYCLES-1, so bus_req spans exactly TIMEOUT_CYCLES cycles.
                    breq_d  = 1'b0;
                    valid_d = 1'b1;
                    error_d = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (!lsu.mem_req) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
            breq_q   <= 1'b0;
            bwe_q    <= 1'b0;
            baddr_q  <= '0;
            bbe_q    <= '0;
            bwdata_q <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            uns_q    <= 1'b0;
            off_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
            breq_q   <= breq_d;
            bwe_q    <= bwe_d;
            baddr_q  <= baddr_d;
            bbe_q    <= bbe_d;
            bwdata_q <= bwdata_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            be_q     <= be_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
        end
    end

    assign lsu.mem_valid = valid_q;
    assign lsu.mem_rdata = rdata_q;
    assign lsu.mem_error = error_q;
    assign lsu.bus_req   = breq_q;
    assign lsu.bus_we    = bwe_q;
    assign lsu.bus_addr  = baddr_q;
    assign lsu.bus_be    = bbe_q;
    assign lsu.bus_wdata = bwdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit with TIMEOUT_CYCLES = 4. Each
//   transaction task derives the expected outputs of every cycle from the
//   request (byte-wise load model, error rules, handshake timing); one
//   negedge process compares all DUT outputs to those expectations and to
//   occasional literal pins.
module tb_load_store_unit;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) lsu_if ();

    load_store_unit #(
        .DATA_WIDTH     (32),
        .BYTE_DATA_WIDTH(4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lsu(lsu_if.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic        chk_en = 1'b0;
    logic        exp_valid, exp_err, exp_breq, exp_bwe;
    logic [31:0] exp_rdata, exp_baddr, exp_bwd;
    logic [3:0]  exp_bbe;

    // Literal pin: 0 rdata, 1 bus_wdata, 2 bus_be, 3 bus_addr, 4 mem_error
    logic        pin_en = 1'b0;
    int          pin_sig = 0;
    logic [31:0] pin_val = '0;
    string       pin_name = "";

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("mem_valid", 32'(lsu_if.mem_valid), 32'(exp_valid));
            cmp("mem_rdata", lsu_if.mem_rdata, exp_rdata);
            cmp("mem_error", 32'(lsu_if.mem_error), 32'(exp_err));
            cmp("bus_req", 32'(lsu_if.bus_req), 32'(exp_breq));
            cmp("bus_we", 32'(lsu_if.bus_we), 32'(exp_bwe));
            cmp("bus_addr", lsu_if.bus_addr, exp_baddr);
            cmp("bus_be", 32'(lsu_if.bus_be), 32'(exp_bbe));
            cmp("bus_wdata", lsu_if.bus_wdata, exp_bwd);
        end
        if (pin_en) begin
            case (pin_sig)
                0:       cmp(pin_name, lsu_if.mem_rdata, pin_val);
                1:       cmp(pin_name, lsu_if.bus_wdata, pin_val);
                2:       cmp(pin_name, 32'(lsu_if.bus_be), pin_val);
                3:       cmp(pin_name, lsu_if.bus_addr, pin_val);
                default: cmp(pin_name, 32'(lsu_if.mem_error), pin_val);
            endcase
        end
    end

    // Load result built byte by byte from the selected lanes.
    function automatic logic [31:0] model_load(input logic [31:0] word, input int off,
                                               input logic [3:0] be, input logic uns);
        int          n;
        logic [31:0] v;
        logic [7:0]  b;
        n = (be == 4'b0001) ? 1 : (be == 4'b0011) ? 2 : 4;
        v = '0;
        for (int i = 0; i < n; i++) begin
            b = word[8*(off+i) +: 8];
            v[8*i +: 8] = b;
        end
        if (!uns && n < 4 && v[8*n-1]) begin
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input int sig, input logic [31:0] val);
        pin_name = name;
        pin_sig  = sig;
        pin_val  = val;
        pin_en   = 1'b1;
        @(negedge clk);
        #1;
        pin_en = 1'b0;
    endtask

    task automatic zero_exp();
        exp_valid = 1'b0; exp_err = 1'b0; exp_breq = 1'b0; exp_bwe = 1'b0;
        exp_rdata = '0; exp_baddr = '0; exp_bwd = '0; exp_bbe = '0;
    endtask

    // ack_at: bus cycle (1-based) carrying bus_ack; 0 = never ack.
    // hold: cycles mem_req stays high in DONE (first one carries a stray ack).
    task automatic txn(input logic we, input logic [3:0] be, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] rd, input int hold);
        logic bad;
        logic done;
        int   off;
        int   i;
        off = int'(addr[1:0]);
        bad = !(be == 4'b0001 || be == 4'b0011 || be == 4'b1111)
              || (be == 4'b0011 && addr[0]) || (be == 4'b1111 && off != 0);
        lsu_if.mem_req = 1'b1;
        lsu_if.mem_we = we;
        lsu_if.mem_byte_enable = be;
        lsu_if.mem_unsigned = uns;
        lsu_if.mem_addr = addr;
        lsu_if.mem_wdata = wd;
        step();
        // Request fields must already be captured; scramble them.
        lsu_if.mem_we = ~we;
        lsu_if.mem_byte_enable = 4'b0101;
        lsu_if.mem_unsigned = ~uns;
        lsu_if.mem_addr = ~addr;
        lsu_if.mem_wdata = ~wd;
        if (bad) begin
            exp_valid = 1'b1; exp_err = 1'b1; exp_rdata = '0;
        end else begin
            exp_breq  = 1'b1;
            exp_bwe   = we;
            exp_baddr = addr & 32'hFFFF_FFFC;
            exp_bbe   = 4'(be << off);
            exp_bwd   = wd << (8 * off);
            done = 1'b0;
            i = 1;
            while (!done) begin
                lsu_if.bus_ack = (i == ack_at);
                lsu_if.bus_rdata = (i == ack_at) ? rd : $urandom;
                step();
                lsu_if.bus_ack = 1'b0;
                if (i == ack_at) begin
                    exp_breq = 1'b0; exp_valid = 1'b1; exp_err = 1'b0;
                    exp_rdata = we ? 32'h0 : model_load(rd, off, be, uns);
                    done = 1'b1;
                end else if (i == TMO) begin
                    exp_breq = 1'b0; exp_valid = 1'b1; exp_err = 1'b1; exp_rdata = '0;
                    done = 1'b1;
                end
                i++;
            end
        end
        for (int h = 0; h < hold; h++) begin
            lsu_if.bus_ack = (h == 0);
            lsu_if.bus_rdata = $urandom;
            step();
            lsu_if.bus_ack = 1'b0;
        end
        lsu_if.mem_req = 1'b0;
        step();
        exp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        lsu_if.mem_req = 1'b0; lsu_if.mem_we = 1'b0; lsu_if.mem_byte_enable = '0;
        lsu_if.mem_unsigned = 1'b0; lsu_if.mem_addr = '0; lsu_if.mem_wdata = '0;
        lsu_if.bus_rdata = '0; lsu_if.bus_ack = 1'b0;
        zero_exp();
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Aligned LW, ack on 3rd bus cycle
        txn(1'b0, 4'b1111, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 2);
        pin("lw_rdata", 0, 32'hDEADBEEF);
        pin("lw_addr", 3, 32'h100);

        // LB / LBU at offset 3
        txn(1'b0, 4'b0001, 1'b0, 32'h203, 32'h0, 1, 32'h80112233, 1);
        pin("lb_rdata", 0, 32'hFFFFFF80);
        pin("lb_be", 2, 32'h8);
        txn(1'b0, 4'b0001, 1'b1, 32'h203, 32'h0, 2, 32'h80112233, 0);
        pin("lbu_rdata", 0, 32'h00000080);

        // Other extension cases
        txn(1'b0, 4'b0011, 1'b0, 32'h402, 32'h0, 1, 32'h9ABC1234, 1);
        txn(1'b0, 4'b0011, 1'b1, 32'h400, 32'h0, 2, 32'h1234F00D, 1);
        pin("lhu_rdata", 0, 32'h0000F00D);
        txn(1'b0, 4'b0001, 1'b0, 32'h501, 32'h0, 1, 32'h00007F00, 1);

        // SH at offset 2
        txn(1'b1, 4'b0011, 1'b0, 32'h302, 32'h0000ABCD, 2, 32'hFFFFFFFF, 1);
        pin("sh_wdata", 1, 32'hABCD0000);
        pin("sh_be", 2, 32'hC);
        pin("sh_rdata", 0, 32'h0);
        txn(1'b1, 4'b0001, 1'b0, 32'h601, 32'h000000A5, 1, 32'h0, 1);

        // Misaligned LW, misaligned LH, invalid enable
        txn(1'b0, 4'b1111, 1'b0, 32'h101, 32'h0, 1, 32'h12345678, 2);
        pin("mis_lw_err", 4, 32'h1);
        txn(1'b0, 4'b0011, 1'b0, 32'h105, 32'h0, 1, 32'h12345678, 1);
        txn(1'b0, 4'b0101, 1'b0, 32'h100, 32'h0, 1, 32'h12345678, 1);
        pin("bad_be_err", 4, 32'h1);

        // Timeout, late ack ignored, then a normal request
        txn(1'b0, 4'b1111, 1'b0, 32'h700, 32'h0, 0, 32'h0, 2);
        pin("tmo_rdata", 0, 32'h0);
        pin("tmo_err", 4, 32'h1);
        lsu_if.bus_ack = 1'b1; lsu_if.bus_rdata = 32'hCAFEF00D;
        step();
        lsu_if.bus_ack = 1'b0;
        step();
        txn(1'b0, 4'b1111, 1'b0, 32'h704, 32'h0, 4, 32'h0BADCAFE, 1);

        // Reset during BUS, then a stray ack
        lsu_if.mem_req = 1'b1; lsu_if.mem_we = 1'b1; lsu_if.mem_byte_enable = 4'b1111;
        lsu_if.mem_unsigned = 1'b0; lsu_if.mem_addr = 32'h40; lsu_if.mem_wdata = 32'h1234;
        step();
        exp_breq = 1'b1; exp_bwe = 1'b1; exp_baddr = 32'h40; exp_bbe = 4'b1111; exp_bwd = 32'h1234;
        step();
        rst = 1'b1;
        step();
        zero_exp();
        rst = 1'b0;
        lsu_if.mem_req = 1'b0;
        lsu_if.bus_ack = 1'b1;
        step();
        lsu_if.bus_ack = 1'b0;
        step();

        // Back-to-back requests
        txn(1'b0, 4'b1111, 1'b0, 32'h800, 32'h0, 1, 32'h11223344, 0);
        txn(1'b0, 4'b0011, 1'b0, 32'h806, 32'h0, 1, 32'h8001AAAA, 0);
        pin("b2b_rdata", 0, 32'hFFFF8001);
        step();

        chk_en = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory responder for the decode unit's `mem_req` / `mem_valid` four-phase handshake. It latches the address, store data and byte enables, and runs one transaction on a word-addressed data bus. On loads it shifts and extends the read data. It reports misalignment or bus timeout, and sits between decode/ALU/register file and data memory.

## Interface
- `DATA_WIDTH`, 32, data/address width; only 32 supported.
- `BYTE_DATA_WIDTH`, 4, byte lanes; must equal `DATA_WIDTH`/8.
- `TIMEOUT_CYCLES`, 16, max cycles waiting for `bus_ack`; 0 disables the timeout.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_req`  in  1  access request from decode; held until `mem_valid` is seen.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_byte_enable`  in  4  access size: 0001 byte, 0011 half, 1111 word; any other value is invalid.
- `mem_unsigned`  in  1  load zero-extend (LBU/LHU); 0 = sign-extend.
- `mem_addr`  in  32  byte address (ALU result `q`).
- `mem_wdata`  in  32  store data (rs2), right-justified.
- `mem_valid`  out  1  access complete; held high until `mem_req` falls.
- `mem_rdata`  out  32  extended load result; valid while `mem_valid` = 1.
- `mem_error`  out  1  misaligned, invalid enable, or timeout; valid while `mem_valid` = 1.
- `bus_req`  out  1  bus request; held until `bus_ack` or timeout.
- `bus_we`  out  1  bus write.
- `bus_addr`  out  32  word address, `{mem_addr[31:2],2'b00}`.
- `bus_be`  out  4  lane enables, `mem_byte_enable << mem_addr[1:0]`.
- `bus_wdata`  out  32  `mem_wdata << (8*mem_addr[1:0])`.
- `bus_rdata`  in  32  read word; sampled in the `bus_ack` cycle.
- `bus_ack`  in  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, BUS, DONE. All outputs are registered.
- **IDLE.**
  - On `mem_req`=1, latch `mem_we`, `mem_byte_enable`, `mem_unsigned`, `mem_addr[1:0]`, `mem_addr` and `mem_wdata`.
  - Check the request:
    - Invalid enable: any value other than 0001/0011/1111.
    - Misaligned half: enable 0011 with `addr[0]`=1.
    - Misaligned word: enable 1111 with `addr[1:0]`≠0.
  - On any check failure: go to DONE with `mem_error`=1 and `mem_rdata`=0. No bus access is made.
  - Otherwise: drive the bus signals, set `bus_req`=1, clear the timeout counter, go to BUS.
- **BUS.**
  - On `bus_ack`: `bus_req`←0, go to DONE, `mem_error`=0.
    - Load: `mem_rdata` = (`bus_rdata` >> 8*offset), then extended.
      - Byte: bit 7 extended, or zeros when `mem_unsigned`=1.
      - Half: bit 15 extended, or zeros when `mem_unsigned`=1.
      - Word: passed unchanged.
    - Store: `mem_rdata`=0.
  - Timeout: when the counter reaches `TIMEOUT_CYCLES`-1 without an ack, `bus_req`←0, `mem_error`=1, `mem_rdata`=0, go to DONE.
  - The counter saturates and does not wrap.
- **DONE.**
  - `mem_valid`=1.
  - When `mem_req`=0, `mem_valid`←0 and go to IDLE.
  - `mem_rdata` and `mem_error` hold until the next accepted request.
- Deviations from the handshake:
  - `mem_req` dropping during BUS: the bus transaction still completes. DONE then sees `mem_req`=0, so `mem_valid` pulses for one cycle.
  - `bus_ack` in IDLE or DONE is ignored.
- Bus outputs other than `bus_req` hold their last value when idle.

## Timing
- Reset: state IDLE; all outputs 0 (`mem_valid`, `mem_rdata`, `mem_error`, `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`); counter 0.
- A reset during BUS drops `bus_req` on the next edge. A late `bus_ack` is ignored.
- `mem_req` high at edge N in IDLE → `bus_req`=1 from N+1.
- `bus_ack` at edge N+k → `mem_valid`=1 and `mem_rdata` valid from N+k+1.
- With zero-wait ack (k=1), `mem_valid` rises 2 cycles after the request edge.
- Error path: `mem_valid` rises 1 cycle after the request edge.
- `mem_req` low at edge M in DONE → `mem_valid`=0 from M+1. A new request can be accepted at M+1 at the earliest.
- Timeout: `bus_req` is high for exactly `TIMEOUT_CYCLES` cycles, then `mem_valid`=1 with `mem_error`=1.

## Test plan
1. **Aligned LW.**
   - Stimulus: addr 0x100, be 1111; `bus_ack` on the 3rd bus cycle with rdata 0xDEADBEEF.
   - Response: `bus_addr`=0x100, `bus_be`=1111; `mem_rdata`=0xDEADBEEF, `mem_error`=0; `mem_valid` falls 1 cycle after `mem_req` falls.
2. **LB / LBU at offset 3.**
   - Stimulus: addr 0x203, rdata 0x80112233.
   - Response: `bus_be`=1000; LB gives 0xFFFFFF80; LBU gives 0x00000080.
3. **SH at offset 2.**
   - Stimulus: addr 0x302, wdata 0x0000ABCD, `mem_we`=1.
   - Response: `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCD0000; `mem_rdata`=0.
4. **Misaligned LW and LH, plus invalid enable.**
   - Stimulus: LW at addr 0x101; LH at addr 0x105; be 0101.
   - Response: `bus_req` never asserts; `mem_valid`=1 and `mem_error`=1 one cycle after the request.
5. **Timeout.**
   - Stimulus: `TIMEOUT_CYCLES`=4, no ack.
   - Response: `bus_req` high for 4 cycles, then `mem_error`=1, `mem_rdata`=0. A later ack is ignored, and the next request completes normally.
6. **Reset mid-BUS and back-to-back requests.**
   - Reset mid-BUS: `bus_req` and `mem_valid` are 0 after the reset edge; a stray ack is ignored.
   - Back-to-back: two requests with `mem_req` re-raised the cycle after `mem_valid` falls both complete with correct data.
